// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets and register-select decode for machine_timer
package timer_pkg;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } timer_reg_e;

  // Byte-lane bits are masked off so any offset within a word selects that word.
  function automatic timer_reg_e decode_reg(input logic [15:0] addr);
    logic [15:0] word;
    word = addr & 16'hFFFC;
    case (word)
      MSIP_OFF:        return REG_MSIP;
      MTIMECMP_LO_OFF: return REG_CMP_LO;
      MTIMECMP_HI_OFF: return REG_CMP_HI;
      MTIME_LO_OFF:    return REG_TIME_LO;
      MTIME_HI_OFF:    return REG_TIME_HI;
      default:         return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into one tick pulse every PRESCALE cycles
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(PRESCALE - 1));

  // A software write to mtime restarts the tick phase so the new value holds a full period.
  always_ff @(posedge clk) begin
    if (reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - CLINT-subset machine timer and software interrupt for one hart
// Optional tick prescaler enabled by defining TIMER_PRESCALER_EN.
module machine_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        tick;
  timer_reg_e  sel;
  logic        wr_en;
  logic        time_wr;
  logic [31:0] rd_data;

  always_comb begin
    sel     = decode_reg(req_addr);
    wr_en   = req_valid && req_write;
    time_wr = wr_en && ((sel == REG_TIME_LO) || (sel == REG_TIME_HI));
  end

`ifdef TIMER_PRESCALER_EN
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (time_wr),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    rd_data = '0;
    case (sel)
      REG_MSIP:    rd_data = {31'b0, msip};
      REG_CMP_LO:  rd_data = mtimecmp[31:0];
      REG_CMP_HI:  rd_data = mtimecmp[63:32];
      REG_TIME_LO: rd_data = mtime[31:0];
      REG_TIME_HI: rd_data = mtime[63:32];
      default:     rd_data = '0;
    endcase
  end

  // A half-word write to mtime replaces the tick for that cycle; the lo half never carries.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= '0;
    end else if (time_wr) begin
      if (sel == REG_TIME_LO) begin
        mtime[31:0] <= req_wdata;
      end else begin
        mtime[63:32] <= req_wdata;
      end
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (wr_en) begin
      case (sel)
        REG_MSIP:   msip            <= req_wdata[0];
        REG_CMP_LO: mtimecmp[31:0]  <= req_wdata;
        REG_CMP_HI: mtimecmp[63:32] <= req_wdata;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_interrupt <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_error      <= 1'b0;
    end else begin
      timer_interrupt <= (mtime >= mtimecmp);
      resp_valid      <= req_valid;
      resp_rdata      <= (req_valid && !req_write) ? rd_data : '0;
      resp_error      <= req_valid && (sel == REG_NONE);
    end
  end

  assign software_interrupt = msip;

endmodule

// File: tb/tb_machine_timer.sv
// tb/tb_machine_timer.sv - randomized and directed checks of machine_timer against a behavioural model
module tb_machine_timer;

`ifdef TIMER_PRESCALER_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        timer_interrupt;
  logic        software_interrupt;

  machine_timer #(.PRESCALE(PS)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_rdata         (resp_rdata),
    .resp_error         (resp_error),
    .timer_interrupt    (timer_interrupt),
    .software_interrupt (software_interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  longint unsigned m_time;
  longint unsigned m_cmp;
  bit              m_msip;
  int              m_pcnt;

  bit          e_rv, e_err, e_irq, e_sw;
  logic [31:0] e_rdata;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural model: registers as plain integers, updated once per clock from the bus request.
  task automatic model_step();
    logic [15:0] a;
    logic [31:0] v;
    bit          hit;
    bit          tick;
    bit          time_written;
    if (reset) begin
      m_time = 0; m_cmp = '1; m_msip = 0; m_pcnt = 0;
      e_rv = 0; e_err = 0; e_irq = 0; e_sw = 0; e_rdata = '0;
      return;
    end
    a = req_addr & 16'hFFFC;
    e_irq = (m_time >= m_cmp);
    hit = 1;
    case (a)
      16'h0000: v = {31'b0, m_msip};
      16'h4000: v = m_cmp[31:0];
      16'h4004: v = m_cmp[63:32];
      16'hBFF8: v = m_time[31:0];
      16'hBFFC: v = m_time[63:32];
      default:  begin v = '0; hit = 0; end
    endcase
    e_rv    = req_valid;
    e_err   = req_valid && !hit;
    e_rdata = (req_valid && !req_write) ? v : '0;
    tick = (m_pcnt == PS - 1);
    time_written = 0;
    if (req_valid && req_write && hit) begin
      case (a)
        16'h0000: m_msip = req_wdata[0];
        16'h4000: m_cmp  = {m_cmp[63:32], req_wdata};
        16'h4004: m_cmp  = {req_wdata, m_cmp[31:0]};
        16'hBFF8: begin m_time = {m_time[63:32], req_wdata}; time_written = 1; end
        16'hBFFC: begin m_time = {req_wdata, m_time[31:0]}; time_written = 1; end
        default: ;
      endcase
    end
    if (time_written) begin
      m_pcnt = 0;
    end else begin
      if (tick) m_time = m_time + 1;
      m_pcnt = tick ? 0 : m_pcnt + 1;
    end
    e_sw = m_msip;
  endtask

  task automatic step(input bit r, input bit v, input bit w, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = r; req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_resp_valid", resp_valid, e_rv);
      check("cmp_resp_rdata", resp_rdata, e_rdata);
      check("cmp_resp_error", resp_error, e_err);
      check("cmp_timer_interrupt", timer_interrupt, e_irq);
      check("cmp_software_interrupt", software_interrupt, e_sw);
    end
  end

  initial begin
    logic [15:0] ra;
    logic [31:0] rd;
    int          sel;

    step(1, 0, 0, 16'h0, 32'h0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_timer_interrupt", timer_interrupt, 0);
    check("rst_software_interrupt", software_interrupt, 0);
    step(0, 1, 0, 16'h4000, 32'h0);
    step(1, 0, 0, 16'h0, 32'h0);
    check("rst_drops_response", resp_valid, 0);

    step(0, 1, 0, 16'hBFF8, 32'h0);
    check("mtime_lo_after_reset", resp_rdata, 32'h0);
    check("mtime_lo_resp_valid", resp_valid, 1);
    step(0, 1, 0, 16'h4004, 32'h0);
    check("mtimecmp_hi_after_reset", resp_rdata, 32'hFFFF_FFFF);
    check("irq_low_after_reset", timer_interrupt, 0);

    step(0, 1, 1, 16'h4000, 32'd10);
    step(0, 1, 1, 16'h4004, 32'd0);
    step(0, 1, 1, 16'hBFF8, 32'd0);
    for (int k = 1; k <= 10 * PS + 3; k++) begin
      idle();
      check("irq_rise_timing", timer_interrupt, (k >= 10 * PS + 1));
    end
    step(0, 1, 1, 16'h4004, 32'h1);
    idle();
    check("irq_cleared_by_cmp", timer_interrupt, 0);

    step(0, 1, 1, 16'hBFF8, 32'hFFFF_FFFF);
    step(0, 1, 1, 16'hBFFC, 32'h0);
    repeat (2 * PS - 1) idle();
    step(0, 1, 0, 16'hBFFC, 32'h0);
    check("carry_hi", resp_rdata, 32'h1);
    step(0, 1, 0, 16'hBFF8, 32'h0);
    check("carry_lo", resp_rdata, 32'h1);

    step(0, 1, 1, 16'h0000, 32'h1);
    check("msip_set", software_interrupt, 1);
    step(0, 1, 0, 16'h0000, 32'h0);
    check("msip_read", resp_rdata, 32'h1);
    step(0, 1, 1, 16'h0000, 32'h0);
    check("msip_clear", software_interrupt, 0);
    step(0, 1, 1, 16'h0000, 32'hFFFF_FFFE);
    check("msip_bit0_only", software_interrupt, 0);

    step(0, 1, 1, 16'h0000, 32'h1);
    step(0, 1, 0, 16'h1234, 32'h0);
    check("unmapped_valid", resp_valid, 1);
    check("unmapped_error", resp_error, 1);
    check("unmapped_rdata", resp_rdata, 32'h0);
    step(0, 1, 1, 16'h1234, 32'h0);
    check("unmapped_wr_error", resp_error, 1);
    step(0, 1, 0, 16'h0002, 32'h0);
    check("msip_unchanged", resp_rdata, 32'h1);
    check("msip_read_no_error", resp_error, 0);

    step(1, 0, 0, 16'h0, 32'h0);
    repeat (40) idle();
    step(0, 1, 0, 16'hBFF8, 32'h0);
    check("mtime_after_40", resp_rdata, 32'(40 / PS));
    step(0, 1, 1, 16'hBFF8, 32'd100);
    repeat (PS) idle();
    step(0, 1, 0, 16'hBFF8, 32'h0);
    check("mtime_write_restart", resp_rdata, 32'd101);

    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: ra = 16'h0000;
        1: ra = 16'h4000;
        2: ra = 16'h4004;
        3: ra = 16'hBFF8;
        4: ra = 16'hBFFC;
        default: ra = 16'($urandom);
      endcase
      ra = ra | 16'($urandom_range(0, 3));
      rd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 64)) : $urandom;
      if (sel == 2 || sel == 4) rd = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), $urandom_range(0, 1), ra, rd);
    end
    idle();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
